// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and drives IF/ID.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets go to TRAP_PC with a trap pulse.
module fetch_pc_unit #(
    parameter int unsigned         DATA_W   = 32,
    parameter logic [DATA_W-1:0]   RESET_PC = '0,
    parameter logic [DATA_W-1:0]   TRAP_PC  = 'h80
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic [DATA_W-1:0] branch_pc,
    input  logic [DATA_W-1:0] jump_pc,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_id_instruction,
    output logic [DATA_W-1:0] if_id_updated_pc,
    output logic              if_id_valid,
    output logic              misalign_trap
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] hold_instr;
    logic [DATA_W-1:0] hold_pc4;
    logic [DATA_W-1:0] pending_pc;
    logic              discard;
    logic              redirect;
    logic [DATA_W-1:0] raw_tgt;
    logic [DATA_W-1:0] tgt;
    logic              tgt_mis;

    assign pc4      = pc + DATA_W'(4);
    assign redirect = (jump | branch_taken) && (state != IDLE);
    assign raw_tgt  = jump ? jump_pc : branch_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q;
    assign tgt_mis       = (raw_tgt[1:0] != 2'b00);
    assign tgt           = tgt_mis ? TRAP_PC : raw_tgt;
    assign misalign_trap = trap_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) trap_q <= 1'b0;
        else         trap_q <= redirect && tgt_mis;
    end
`else
    logic unused_bits;
    assign tgt_mis       = 1'b0;
    assign tgt           = {raw_tgt[DATA_W-1:2], 2'b00};
    assign misalign_trap = 1'b0;
    assign unused_bits   = ^{TRAP_PC, raw_tgt[1:0], tgt_mis};
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (!redirect && imem_ack && !discard && stall)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (redirect || !stall)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = pc & ~DATA_W'(3);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc                <= RESET_PC;
            if_id_instruction <= '0;
            if_id_updated_pc  <= '0;
            if_id_valid       <= 1'b0;
            hold_instr        <= '0;
            hold_pc4          <= '0;
            pending_pc        <= '0;
            discard           <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (redirect) begin
                        if_id_valid <= 1'b0;
                        if (imem_ack) begin
                            pc      <= tgt;
                            discard <= 1'b0;
                        end else begin
                            // Address must stay stable until the in-flight request is acked.
                            pending_pc <= tgt;
                            discard    <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        if (discard) begin
                            pc      <= pending_pc;
                            discard <= 1'b0;
                        end else if (!stall) begin
                            if_id_instruction <= imem_rdata;
                            if_id_updated_pc  <= pc4;
                            if_id_valid       <= 1'b1;
                            pc                <= pc4;
                        end else begin
                            hold_instr <= imem_rdata;
                            hold_pc4   <= pc4;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        if_id_valid <= 1'b0;
                        pc          <= tgt;
                    end else if (!stall) begin
                        if_id_instruction <= hold_instr;
                        if_id_updated_pc  <= hold_pc4;
                        if_id_valid       <= 1'b1;
                        pc                <= hold_pc4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
